// File: rtl/queue_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the queue push arbiter.
package queue_arb_pkg;

  localparam int CNT_W   = 16;
  localparam int MAX_REQ = 16;
  localparam int PTR_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ_HI,
    REQ_LO
  } arb_state_t;

  // One-hot grant to the first valid bit at or after ptr, wrapping modulo nreq.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 nreq);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    logic [PTR_W-1:0]   idx;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % nreq);
      if (!found && (i < nreq) && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/queue_push_arbiter_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/queue_push_arbiter.sv
// Round-robin arbiter sharing the 4-phase push port of the bundled-data queue
// between NREQ clocked requesters; each word is tagged with its source index.
module queue_push_arbiter
  import queue_arb_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int PWIDTH = 8,
  localparam int IDW    = $clog2(NREQ),
  localparam int QWIDTH = PWIDTH + IDW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          in_valid,
  input  logic [NREQ*PWIDTH-1:0]   in_data,
  output logic [NREQ-1:0]          in_ready,
  output logic [QWIDTH-1:0]        q_data,
  output logic                     q_req,
  input  logic                     q_ack,
  output logic [CNT_W-1:0]         push_cnt
);

  arb_state_t         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [QWIDTH-1:0]  q_data_q, q_data_d;
  logic               q_req_q, q_req_d;
  logic [CNT_W-1:0]   push_cnt_q, push_cnt_d;

  logic               ack_s;
  logic               sync_warm;
  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] grant_all;
  logic [MAX_REQ-1:0] grant_unused;
  logic [IDW-1:0]     win_idx;
  logic [PWIDTH-1:0]  win_data;
  logic               transfer;

  sync2 u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (q_ack),
    .q_o   (ack_s)
  );

  // Goes high two edges after reset release, once ack_s reflects the real q_ack level;
  // until then a queue still returning to zero could be mistaken for idle.
  sync2 u_warm_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (1'b1),
    .q_o   (sync_warm)
  );

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = in_valid;
    grant_all             = rr_pick(valid_ext, PTR_W'(rr_ptr_q), NREQ);
  end

  assign grant_unused = grant_all;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    in_ready = '0;
    if ((state_q == IDLE) && sync_warm && !ack_s) begin
      in_ready = grant_all[NREQ-1:0];
    end
  end

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (in_ready[i]) begin
        win_idx  = IDW'(i);
        win_data = in_data[i*PWIDTH +: PWIDTH];
      end
    end
  end

  assign transfer = |(in_ready & in_valid);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    q_data_d   = q_data_q;
    q_req_d    = q_req_q;
    push_cnt_d = push_cnt_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          q_data_d = {win_idx, win_data};
          rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
          state_d  = SETUP;
        end
      end
      SETUP: begin
        // Data has been stable for a full cycle before the request rises.
        q_req_d = 1'b1;
        state_d = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s) begin
          q_req_d = 1'b0;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          push_cnt_d = push_cnt_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      q_data_q   <= '0;
      q_req_q    <= 1'b0;
      push_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      q_data_q   <= q_data_d;
      q_req_q    <= q_req_d;
      push_cnt_q <= push_cnt_d;
    end
  end

  assign q_data   = q_data_q;
  assign q_req    = q_req_q;
  assign push_cnt = push_cnt_q;

endmodule

// File: tb/tb_queue_push_arbiter.sv
// Self-checking bench for queue_push_arbiter: grant table, scoreboard on q_data,
// throughput, slow queue, reset mid-handshake and counter wrap.
module tb_queue_push_arbiter;

  localparam int NREQ   = 4;
  localparam int PWIDTH = 8;
  localparam int QWIDTH = 10;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        in_valid;
  logic [NREQ*PWIDTH-1:0] in_data;
  logic [NREQ-1:0]        in_ready;
  logic [QWIDTH-1:0]      q_data;
  logic                   q_req;
  logic                   q_ack;
  logic [15:0]            push_cnt;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;
  int model_ptr = 0;
  int model_cnt = 0;
  int ack_delay = 0;
  bit model_on  = 1'b1;

  logic [QWIDTH-1:0] sb[$];

  typedef struct {
    logic [3:0] v;
    logic [3:0] g;
    bit         rst;
  } vec_t;

  vec_t tbl[14];

  queue_push_arbiter #(.NREQ(NREQ), .PWIDTH(PWIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .q_data   (q_data),
    .q_req    (q_req),
    .q_ack    (q_ack),
    .push_cnt (push_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] model_pick(input logic [3:0] v, input int ptr);
    logic [3:0] g;
    g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (g == 4'b0 && v[(ptr + k) % NREQ]) g[(ptr + k) % NREQ] = 1'b1;
    end
    return g;
  endfunction

  function automatic int onehot_idx(input logic [3:0] g);
    int r;
    r = 0;
    for (int k = 0; k < NREQ; k++) if (g[k]) r = k;
    return r;
  endfunction

  // Queue model: ack follows req after ack_delay clock edges (zero means immediately).
  initial begin
    q_ack = 1'b0;
    forever begin
      @(q_req);
      if (model_on) begin
        if (ack_delay > 0) repeat (ack_delay) @(posedge clk);
        #1 q_ack = q_req;
      end
    end
  end

  // Scoreboard: each rising q_req must carry the next expected word, already stable.
  logic              prev_req = 1'b0;
  logic [QWIDTH-1:0] prev_qd  = '0;
  always @(negedge clk) begin : monitor
    logic [QWIDTH-1:0] e;
    if (q_req === 1'b1 && prev_req === 1'b0) begin
      if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("q_data_at_req", q_data, e);
        check("q_data_setup", q_data, prev_qd);
      end
    end
    prev_req <= q_req;
    prev_qd  <= q_data;
  end

  task automatic expect_word(input logic [3:0] g, input logic [31:0] d);
    int idx;
    idx = onehot_idx(g);
    sb.push_back({2'(idx), d[idx*8 +: 8]});
    model_ptr = (idx + 1) % NREQ;
    model_cnt++;
  endtask

  task automatic wait_done(input string tag);
    int g;
    g = 0;
    while (push_cnt !== 16'(model_cnt) && g < 400) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_cnt"}, push_cnt, 16'(model_cnt));
  endtask

  task automatic send(input logic [3:0] v, input logic [31:0] d, input logic [3:0] exp_g,
                      input string tag);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    #1;
    check({tag, "_grant"}, in_ready, exp_g);
    expect_word(exp_g, d);
    @(negedge clk);
    check({tag, "_ready_busy"}, in_ready, 4'b0);
    in_valid = '0;
    wait_done(tag);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    model_ptr = 0;
    model_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int                n, g, k, viol, idx;
    int                t[5];
    logic [3:0]        eg;
    logic [31:0]       d;
    logic [QWIDTH-1:0] exp_qd;
    logic              prev_r;

    tbl[0] = '{4'b0100, 4'b0100, 1'b1};
    for (int i = 1; i <= 8; i++) tbl[i] = '{4'b1111, 4'(4'b0001 << ((i - 1) % 4)), (i == 1)};
    tbl[9]  = '{4'b0011, 4'b0001, 1'b0};
    tbl[10] = '{4'b1001, 4'b1000, 1'b0};
    tbl[11] = '{4'b0110, 4'b0010, 1'b0};
    tbl[12] = '{4'b0010, 4'b0010, 1'b0};
    tbl[13] = '{4'b1010, 4'b1000, 1'b0};

    // Reset state, with requests pending to show they are ignored.
    rst_n    = 1'b0;
    in_valid = 4'hF;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_q_req", q_req, 1'b0);
    check("rst_q_data", q_data, '0);
    check("rst_in_ready", in_ready, 4'b0);
    check("rst_push_cnt", push_cnt, 16'h0);

    // Table: single requester, round-robin over all four, then mixed patterns.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset();
      d = 32'hD4A5_C3F0 ^ {4{8'(i * 17)}};
      send(tbl[i].v, d, tbl[i].g, $sformatf("vec%0d", i));
    end

    // Throughput with an immediate queue.
    n = 0;
    g = 0;
    @(negedge clk);
    in_valid = 4'hF;
    in_data  = 32'h1122_3344;
    while (n < 5 && g < 200) begin
      #1;
      if (|in_ready) begin
        eg = model_pick(4'hF, model_ptr);
        check("tp_grant", in_ready, eg);
        expect_word(eg, in_data);
        t[n] = cyc;
        n++;
      end
      @(negedge clk);
      g++;
    end
    in_valid = '0;
    check("tp_accepts", n, 5);
    for (int i = 1; i < n; i++) check("tp_interval", t[i] - t[i-1], 8);
    wait_done("tp");

    // Slow queue: ack delayed 20 edges on both transitions.
    ack_delay = 20;
    @(negedge clk);
    in_valid = 4'b0001;
    in_data  = 32'h0000_005A;
    #1;
    eg = model_pick(4'b0001, model_ptr);
    check("slow_grant", in_ready, eg);
    expect_word(eg, in_data);
    exp_qd = {2'd0, 8'h5A};
    @(negedge clk);
    #1;
    viol   = 0;
    g      = 0;
    prev_r = 1'b0;
    while (push_cnt !== 16'(model_cnt) && g < 400) begin
      if (in_ready !== 4'b0) viol++;
      if (q_data !== exp_qd) viol++;
      if (prev_r && !q_req && !q_ack) viol++;
      prev_r = q_req;
      @(negedge clk);
      #1;
      g++;
    end
    in_valid = '0;
    check("slow_stable_viol", viol, 0);
    check("slow_latency", g, 47);
    check("slow_cnt", push_cnt, 16'(model_cnt));
    ack_delay = 0;

    // Reset while in REQ_HI with the queue still acking.
    model_on = 1'b0;
    @(negedge clk);
    in_valid = 4'b0010;
    in_data  = 32'h0000_7E00;
    #1;
    eg = model_pick(4'b0010, model_ptr);
    check("mid_grant", in_ready, eg);
    expect_word(eg, in_data);
    g = 0;
    while (q_req !== 1'b1 && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("mid_req_high", q_req, 1'b1);
    q_ack = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_ptr = 0;
    model_cnt = 0;
    check("mid_rst_q_req", q_req, 1'b0);
    check("mid_rst_q_data", q_data, '0);
    check("mid_rst_cnt", push_cnt, 16'h0);
    check("mid_rst_ready", in_ready, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    viol  = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (in_ready !== 4'b0) viol++;
    end
    check("mid_no_grant_while_ack", viol, 0);
    q_ack = 1'b0;
    k     = 0;
    while (in_ready === 4'b0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("mid_grant_latency", k, 2);
    eg = model_pick(4'b0010, model_ptr);
    check("mid_regrant", in_ready, eg);
    expect_word(eg, in_data);
    model_on = 1'b1;
    @(negedge clk);
    in_valid = '0;
    wait_done("mid");

    // Counter wrap from 16'hFFFF.
    @(negedge clk);
    force dut.push_cnt_q = 16'hFFFF;
    #1 release dut.push_cnt_q;
    @(negedge clk);
    check("wrap_preload", push_cnt, 16'hFFFF);
    model_cnt = 65535;
    eg = model_pick(4'b1000, model_ptr);
    send(4'b1000, 32'h9900_0000, eg, "wrap");
    check("wrap_zero", push_cnt, 16'h0);

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
